// File: rtl/stack_engine.sv
// ---------------------------------------------------------------------------
// stack_engine
//
// Multi-cycle stack sequencer. Accepts one PUSH / POP / CALL / RET / INT / RTI
// operation per op_valid/op_ready handshake. It snapshots SP at acceptance,
// runs the memory traffic, then commits register-file, SP, PC and flag
// updates. done pulses on the last cycle of every operation, and the engine
// then returns to IDLE.
//
// Build option:
//   STACK_INT_EN  defined   -> INT and RTI sequences are implemented.
//                 undefined -> opcodes 4/5 take the illegal path, and
//                              flags_load/flags_out stay 0.
//
// Ports:
//   clk, reset (async, active-low)
//   op_valid/op_ready       operation handshake (op_ready combinational)
//   op_code/op_reg/op_data/op_target, sp_in, flags_in   operation operands
//   mem_we/mem_re/mem_addr/mem_wdata/mem_rdata          data memory (sync read)
//   rf_we/rf_waddr/rf_wdata                             register-file write
//   update_sp/new_sp, pc_load/pc_value                  SP / PC commit
//   flags_load/flags_out                                CCR restore
//   done, stack_ovf, stack_unf, illegal                 completion / status
// ---------------------------------------------------------------------------
module stack_engine #(
    parameter int              DW     = 8,
    parameter logic [DW-1:0]   SP_RST = DW'(8'hFF)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          op_valid,
    output logic          op_ready,
    input  logic [2:0]    op_code,
    input  logic [1:0]    op_reg,
    input  logic [DW-1:0] op_data,
    input  logic [DW-1:0] op_target,
    input  logic [DW-1:0] sp_in,
    input  logic [3:0]    flags_in,
    output logic          mem_we,
    output logic          mem_re,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          rf_we,
    output logic [1:0]    rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic          update_sp,
    output logic [DW-1:0] new_sp,
    output logic          pc_load,
    output logic [DW-1:0] pc_value,
    output logic          flags_load,
    output logic [3:0]    flags_out,
    output logic          done,
    output logic          stack_ovf,
    output logic          stack_unf,
    output logic          illegal
);

    localparam logic [2:0] OP_PUSH = 3'd0;
    localparam logic [2:0] OP_POP  = 3'd1;
    localparam logic [2:0] OP_CALL = 3'd2;
    localparam logic [2:0] OP_RET  = 3'd3;
`ifdef STACK_INT_EN
    localparam logic [2:0] OP_INT  = 3'd4;
    localparam logic [2:0] OP_RTI  = 3'd5;
`endif

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_PSH_W  = 4'd1,
        S_POP_R  = 4'd2,
        S_POP_W  = 4'd3,
        S_ILL    = 4'd4
`ifdef STACK_INT_EN
        ,
        S_INT_W1 = 4'd5,
        S_INT_W2 = 4'd6,
        S_RTI_R1 = 4'd7,
        S_RTI_R2 = 4'd8,
        S_RTI_W  = 4'd9
`endif
    } state_e;

    state_e state_q, state_d;

    logic          accept;
    logic [2:0]    code_q;
    logic [1:0]    reg_q;
    logic [DW-1:0] data_q;
    logic [DW-1:0] target_q;
    logic [DW-1:0] sp_q;
`ifdef STACK_INT_EN
    logic [3:0]    flags_q;
`endif

    // SP arithmetic carried one bit wider: the extra MSB is the wrap
    // indicator (borrow for decrements, carry for increments).
    logic [DW:0] sp_m1, sp_p1;
`ifdef STACK_INT_EN
    logic [DW:0] sp_m2, sp_p2;
`endif

    // SP_RST documents the reset value of R3 elsewhere; flags_in only
    // matters when the interrupt sequences exist.
    logic unused_sink;
`ifdef STACK_INT_EN
    assign unused_sink = ^SP_RST;
`else
    assign unused_sink = ^{SP_RST, flags_in};
`endif

    assign op_ready = (state_q == S_IDLE) && reset;
    assign accept   = op_valid && op_ready;

    assign sp_m1 = {1'b0, sp_q} - (DW+1)'(1);
    assign sp_p1 = {1'b0, sp_q} + (DW+1)'(1);
`ifdef STACK_INT_EN
    assign sp_m2 = {1'b0, sp_q} - (DW+1)'(2);
    assign sp_p2 = {1'b0, sp_q} + (DW+1)'(2);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand snapshot: only meaningful after acceptance, so no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            code_q   <= op_code;
            reg_q    <= op_reg;
            data_q   <= op_data;
            target_q <= op_target;
            sp_q     <= sp_in;
`ifdef STACK_INT_EN
            flags_q  <= flags_in;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        rf_we      = 1'b0;
        rf_waddr   = '0;
        rf_wdata   = '0;
        update_sp  = 1'b0;
        new_sp     = '0;
        pc_load    = 1'b0;
        pc_value   = '0;
        flags_load = 1'b0;
        flags_out  = '0;
        done       = 1'b0;
        stack_ovf  = 1'b0;
        stack_unf  = 1'b0;
        illegal    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (op_code)
                        OP_PUSH, OP_CALL: state_d = S_PSH_W;
                        OP_POP,  OP_RET:  state_d = S_POP_R;
`ifdef STACK_INT_EN
                        OP_INT:           state_d = S_INT_W1;
                        OP_RTI:           state_d = S_RTI_R1;
`endif
                        default:          state_d = S_ILL;
                    endcase
                end
            end

            S_PSH_W: begin
                mem_we    = 1'b1;
                mem_addr  = sp_q;
                mem_wdata = data_q;
                update_sp = 1'b1;
                new_sp    = sp_m1[DW-1:0];
                stack_ovf = sp_m1[DW];
                if (code_q == OP_CALL) begin
                    pc_load  = 1'b1;
                    pc_value = target_q;
                end
                done    = 1'b1;
                state_d = S_IDLE;
            end

            S_POP_R: begin
                mem_re   = 1'b1;
                mem_addr = sp_p1[DW-1:0];
                state_d  = S_POP_W;
            end

            // mem_rdata now holds the value read in S_POP_R.
            S_POP_W: begin
                update_sp = 1'b1;
                stack_unf = sp_p1[DW];
                if (code_q == OP_RET) begin
                    pc_load  = 1'b1;
                    pc_value = mem_rdata;
                    new_sp   = sp_p1[DW-1:0];
                end else if (reg_q == 2'd3) begin
                    // Popping into R3: the popped word becomes the new SP.
                    new_sp = mem_rdata;
                end else begin
                    rf_we    = 1'b1;
                    rf_waddr = reg_q;
                    rf_wdata = mem_rdata;
                    new_sp   = sp_p1[DW-1:0];
                end
                done    = 1'b1;
                state_d = S_IDLE;
            end

            S_ILL: begin
                done    = 1'b1;
                illegal = 1'b1;
                state_d = S_IDLE;
            end

`ifdef STACK_INT_EN
            S_INT_W1: begin
                mem_we    = 1'b1;
                mem_addr  = sp_q;
                mem_wdata = data_q;
                state_d   = S_INT_W2;
            end

            S_INT_W2: begin
                mem_we    = 1'b1;
                mem_addr  = sp_m1[DW-1:0];
                mem_wdata = {{(DW-4){1'b0}}, flags_q};
                update_sp = 1'b1;
                new_sp    = sp_m2[DW-1:0];
                stack_ovf = sp_m2[DW];
                pc_load   = 1'b1;
                pc_value  = target_q;
                done      = 1'b1;
                state_d   = S_IDLE;
            end

            S_RTI_R1: begin
                mem_re   = 1'b1;
                mem_addr = sp_p1[DW-1:0];
                state_d  = S_RTI_R2;
            end

            // Flags word arrives from the R1 read; fetch the return PC.
            S_RTI_R2: begin
                flags_load = 1'b1;
                flags_out  = mem_rdata[3:0];
                mem_re     = 1'b1;
                mem_addr   = sp_p2[DW-1:0];
                state_d    = S_RTI_W;
            end

            S_RTI_W: begin
                pc_load   = 1'b1;
                pc_value  = mem_rdata;
                update_sp = 1'b1;
                new_sp    = sp_p2[DW-1:0];
                stack_unf = sp_p2[DW];
                done      = 1'b1;
                state_d   = S_IDLE;
            end
`endif

            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_stack_engine.sv
module tb_stack_engine;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          op_valid;
    logic          op_ready;
    logic [2:0]    op_code;
    logic [1:0]    op_reg;
    logic [DW-1:0] op_data, op_target, sp_in;
    logic [3:0]    flags_in;
    logic          mem_we, mem_re;
    logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
    logic          rf_we;
    logic [1:0]    rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          update_sp;
    logic [DW-1:0] new_sp;
    logic          pc_load;
    logic [DW-1:0] pc_value;
    logic          flags_load;
    logic [3:0]    flags_out;
    logic          done, stack_ovf, stack_unf, illegal;

    always #5 clk = ~clk;

    stack_engine #(.DW(DW), .SP_RST(8'hFF)) dut (
        .clk(clk), .reset(reset),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .op_reg(op_reg), .op_data(op_data),
        .op_target(op_target), .sp_in(sp_in), .flags_in(flags_in),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .update_sp(update_sp), .new_sp(new_sp),
        .pc_load(pc_load), .pc_value(pc_value),
        .flags_load(flags_load), .flags_out(flags_out),
        .done(done), .stack_ovf(stack_ovf), .stack_unf(stack_unf),
        .illegal(illegal)
    );

    typedef struct packed {
        logic       op_ready;
        logic       mem_we;
        logic       mem_re;
        logic [7:0] mem_addr;
        logic [7:0] mem_wdata;
        logic       rf_we;
        logic [1:0] rf_waddr;
        logic [7:0] rf_wdata;
        logic       update_sp;
        logic [7:0] new_sp;
        logic       pc_load;
        logic [7:0] pc_value;
        logic       flags_load;
        logic [3:0] flags_out;
        logic       done;
        logic       ovf;
        logic       unf;
        logic       ill;
    } obs_t;

    obs_t  exp_q[$];
    string tag_q[$];
    int    nvec = 0;
    int    nfail = 0;
    int    done_cnt = 0;
    logic  mem_init;
    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    logic [7:0] sp_model;

    function automatic logic [7:0] init_val(input int i);
        logic [7:0] v;
        v = 8'(i * 29 + 7);
        if (i == 0) v = 8'h80;
        return v;
    endfunction

    function automatic obs_t blank();
        obs_t r;
        r = '0;
        return r;
    endfunction

    function automatic obs_t observe();
        obs_t r;
        r.op_ready   = op_ready;
        r.mem_we     = mem_we;
        r.mem_re     = mem_re;
        r.mem_addr   = mem_addr;
        r.mem_wdata  = mem_wdata;
        r.rf_we      = rf_we;
        r.rf_waddr   = rf_waddr;
        r.rf_wdata   = rf_wdata;
        r.update_sp  = update_sp;
        r.new_sp     = new_sp;
        r.pc_load    = pc_load;
        r.pc_value   = pc_value;
        r.flags_load = flags_load;
        r.flags_out  = flags_out;
        r.done       = done;
        r.ovf        = stack_ovf;
        r.unf        = stack_unf;
        r.ill        = illegal;
        return r;
    endfunction

    // Synchronous data memory: read data appears the cycle after mem_re.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
        end else begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            if (mem_re) mem_rdata <= mem[mem_addr];
        end
    end

    // Monitor: every cycle with any DUT activity consumes one expected cycle.
    always @(negedge clk) begin
        obs_t  a, e;
        string t;
        if (reset === 1'b1) begin
            a = observe();
            if (a.mem_we | a.mem_re | a.rf_we | a.update_sp | a.pc_load |
                a.flags_load | a.done | a.ovf | a.unf | a.ill) begin
                nvec++;
                if (exp_q.size() == 0) begin
                    nfail++;
                    $display("FAIL unexpected-activity got=%h required=idle", a);
                end else begin
                    e = exp_q.pop_front();
                    t = tag_q.pop_front();
                    if (a !== e) begin
                        nfail++;
                        $display("FAIL %s got=%h required=%h", t, a, e);
                    end
                end
                if (a.done) done_cnt++;
            end
        end
    end

    task automatic push_exp(input obs_t e, input string t);
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    // Reference model: expected per-cycle outputs of one operation.
    task automatic model_op(input logic [2:0] code, input logic [1:0] r,
                            input logic [7:0] d, input logic [7:0] t,
                            input logic [7:0] s, input logic [3:0] f,
                            output logic [7:0] nsp);
        obs_t e;
        logic [7:0] a1, a2, v, v2;
        a1  = s + 8'd1;
        a2  = s + 8'd2;
        nsp = s;
        e   = blank();
        if (code == 3'd0 || code == 3'd2) begin
            e.mem_we = 1; e.mem_addr = s; e.mem_wdata = d;
            e.update_sp = 1; e.new_sp = s - 8'd1; e.done = 1;
            e.ovf = (s == 8'h00);
            if (code == 3'd2) begin e.pc_load = 1; e.pc_value = t; end
            push_exp(e, (code == 3'd2) ? "call" : "push");
            ref_mem[s] = d;
            nsp = s - 8'd1;
        end else if (code == 3'd1 || code == 3'd3) begin
            e.mem_re = 1; e.mem_addr = a1;
            push_exp(e, "pop-read");
            v = ref_mem[a1];
            e = blank();
            e.update_sp = 1; e.done = 1; e.unf = (s == 8'hFF);
            if (code == 3'd3) begin
                e.pc_load = 1; e.pc_value = v; e.new_sp = a1;
            end else if (r == 2'd3) begin
                e.new_sp = v;
            end else begin
                e.rf_we = 1; e.rf_waddr = r; e.rf_wdata = v; e.new_sp = a1;
            end
            push_exp(e, (code == 3'd3) ? "ret-commit" : "pop-commit");
            nsp = e.new_sp;
`ifdef STACK_INT_EN
        end else if (code == 3'd4) begin
            e.mem_we = 1; e.mem_addr = s; e.mem_wdata = d;
            push_exp(e, "int-w1");
            ref_mem[s] = d;
            e = blank();
            e.mem_we = 1; e.mem_addr = s - 8'd1; e.mem_wdata = {4'h0, f};
            e.update_sp = 1; e.new_sp = s - 8'd2;
            e.pc_load = 1; e.pc_value = t; e.done = 1; e.ovf = (s < 8'd2);
            push_exp(e, "int-w2");
            ref_mem[s - 8'd1] = {4'h0, f};
            nsp = s - 8'd2;
        end else if (code == 3'd5) begin
            e.mem_re = 1; e.mem_addr = a1;
            push_exp(e, "rti-r1");
            v  = ref_mem[a1];
            v2 = ref_mem[a2];
            e = blank();
            e.flags_load = 1; e.flags_out = v[3:0];
            e.mem_re = 1; e.mem_addr = a2;
            push_exp(e, "rti-r2");
            e = blank();
            e.pc_load = 1; e.pc_value = v2; e.update_sp = 1; e.new_sp = a2;
            e.done = 1; e.unf = (s >= 8'hFE);
            push_exp(e, "rti-commit");
            nsp = a2;
`endif
        end else begin
            e.done = 1; e.ill = 1;
            push_exp(e, "illegal");
        end
    endtask

    // Called at a falling edge with the engine idle.
    task automatic issue(input logic [2:0] code, input logic [1:0] r,
                         input logic [7:0] d, input logic [7:0] t,
                         input logic [7:0] s, input logic [3:0] f);
        logic [7:0] nsp;
        int start;
        nvec++;
        if (op_ready !== 1'b1) begin
            nfail++;
            $display("FAIL op_ready-idle got=%b required=1", op_ready);
        end
        op_valid = 1'b1; op_code = code; op_reg = r; op_data = d;
        op_target = t; sp_in = s; flags_in = f;
        model_op(code, r, d, t, s, f, nsp);
        start = done_cnt;
        @(posedge clk); #1;
        // Operand inputs are don't-care while busy; scramble them.
        op_valid = 1'($urandom); op_code = 3'($urandom); op_reg = 2'($urandom);
        op_data = 8'($urandom); op_target = 8'($urandom);
        sp_in = 8'($urandom); flags_in = 4'($urandom);
        for (int k = 0; k < 8 && done_cnt == start; k++) begin
            @(negedge clk); #1;
        end
        op_valid = 1'b0;
        if (done_cnt == start) begin
            nvec++; nfail++;
            $display("FAIL done-timeout op=%0d got=no-done required=done", code);
            exp_q.delete(); tag_q.delete();
        end
        sp_model = nsp;
        @(negedge clk);
    endtask

    initial begin
        #3000000;
        $display("FAIL global-timeout got=running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [2:0] c;
        logic [7:0] s;
        obs_t o;
        reset = 1'b0; mem_init = 1'b1; op_valid = 1'b0; op_code = '0;
        op_reg = '0; op_data = '0; op_target = '0; sp_in = '0; flags_in = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        sp_model = 8'hFF;

        repeat (3) @(negedge clk);
        o = observe();
        nvec++;
        if (o !== blank()) begin
            nfail++;
            $display("FAIL reset-outputs got=%h required=%h", o, blank());
        end
        mem_init = 1'b0;
        reset = 1'b1;
        @(negedge clk);

        issue(3'd0, 2'd0, 8'h5A, 8'h00, 8'hFF, 4'h0);   // PUSH
        issue(3'd1, 2'd1, 8'h00, 8'h00, 8'hFE, 4'h0);   // POP R1
        issue(3'd1, 2'd3, 8'h00, 8'h00, 8'hFF, 4'h0);   // POP R3, underflow
        issue(3'd2, 2'd0, 8'h12, 8'h40, 8'h00, 4'h0);   // CALL, overflow
        issue(3'd4, 2'd0, 8'h33, 8'h02, 8'hFF, 4'h9);   // INT
        issue(3'd5, 2'd0, 8'h00, 8'h00, 8'hFD, 4'h0);   // RTI
        issue(3'd3, 2'd2, 8'h00, 8'h00, 8'hFE, 4'h0);   // RET
        issue(3'd6, 2'd1, 8'hAA, 8'h55, 8'h10, 4'h3);   // illegal
        issue(3'd7, 2'd2, 8'hAA, 8'h55, 8'h10, 4'h3);   // illegal
        sp_model = 8'h80;

        // Reset asserted in the second cycle of a multi-cycle operation.
`ifdef STACK_INT_EN
        c = 3'd5;
`else
        c = 3'd1;
`endif
        s = sp_model;
        op_valid = 1'b1; op_code = c; op_reg = 2'd0; op_data = '0;
        op_target = '0; sp_in = s; flags_in = '0;
        model_op(c, 2'd0, 8'h00, 8'h00, s, 4'h0, s);
        @(posedge clk); #1;
        op_valid = 1'b0;
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        o = observe();
        nvec++;
        if (o !== blank()) begin
            nfail++;
            $display("FAIL midop-reset got=%h required=%h", o, blank());
        end
        exp_q.delete(); tag_q.delete();
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        #1;
        nvec++;
        if (op_ready !== 1'b1) begin
            nfail++;
            $display("FAIL ready-after-reset got=%b required=1", op_ready);
        end
        @(negedge clk);
        issue(3'd0, 2'd0, 8'hC3, 8'h00, sp_model, 4'h0);

        for (int n = 0; n < 300; n++) begin
            c = 3'($urandom_range(0, 7));
            s = sp_model;
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 4))
                    0: s = 8'h00;
                    1: s = 8'h01;
                    2: s = 8'hFE;
                    3: s = 8'hFF;
                    default: s = 8'($urandom);
                endcase
            end
            issue(c, 2'($urandom), 8'($urandom), 8'($urandom), s, 4'($urandom));
        end

        repeat (2) @(negedge clk);
        nvec++;
        if (exp_q.size() != 0) begin
            nfail++;
            $display("FAIL leftover-expected got=%0d required=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/stack_engine.md
# stack_engine

Multi-cycle stack sequencer that drives the register file's write and SP-update ports and the data-memory port. It executes PUSH, POP, CALL, RET, INT and RTI as short FSM sequences. The decode stage issues one operation per valid/ready handshake. The engine snapshots SP, performs the memory traffic, then commits the register, SP, PC and flag updates.

## Interface
Parameters:
- DW, 8, data/address width (SP, PC, memory address)
- SP_RST, 8'hFF, informational only; the engine never stores SP

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- op_valid  in  1  operation request
- op_ready  out  1  engine can accept; high only in IDLE with reset deasserted
- op_code  in  3  0 PUSH, 1 POP, 2 CALL, 3 RET, 4 INT, 5 RTI, 6/7 illegal
- op_reg  in  2  register for PUSH source / POP destination (index only, for POP)
- op_data  in  DW  PUSH data, or return PC for CALL/INT
- op_target  in  DW  jump target for CALL, vector for INT
- sp_in  in  DW  current SP (register file R3 read)
- flags_in  in  4  CCR value to save on INT
- mem_we, mem_re  out  1  data-memory write/read strobes
- mem_addr  out  DW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  read data, valid the cycle after mem_re
- rf_we  out  1  register write enable
- rf_waddr  out  2  register write address
- rf_wdata  out  DW  register write data
- update_sp  out  1  SP commit strobe
- new_sp  out  DW  SP commit value
- pc_load  out  1  PC redirect strobe
- pc_value  out  DW  PC redirect value
- flags_load  out  1  CCR restore strobe
- flags_out  out  4  CCR restore value
- done  out  1  one-cycle pulse on the final cycle of every operation
- stack_ovf, stack_unf, illegal  out  1  status pulses, asserted only together with done

## Operation
- Acceptance: op_valid && op_ready at a rising edge latches op_code, op_reg, op_data, op_target, flags_in and S = sp_in. The engine leaves IDLE.
- Arithmetic: all SP and address arithmetic is mod 2^DW.
- stack_ovf: pulses when a push-type operation's decrement wraps below 0x00.
- stack_unf: pulses when a pop-type operation's increment wraps above 0xFF.
- PUSH (PSH_W): mem_we=1, addr=S, wdata=op_data; update_sp=1, new_sp=S-1; done.
- CALL (PSH_W): same as PUSH, plus pc_load=1, pc_value=op_target.
- POP (POP_R, then POP_W):
  - POP_R: mem_re=1, addr=S+1.
  - POP_W: rf_we=1, rf_waddr=op_reg, rf_wdata=mem_rdata; update_sp=1, new_sp=S+1; done.
  - If op_reg==3: rf_we=0 and new_sp=mem_rdata; the popped value becomes SP.
- RET (POP_R, then POP_W): same as POP, but rf_we=0 and pc_load=1 with pc_value=mem_rdata.
- INT (INT_W1, then INT_W2):
  - INT_W1: mem_we, addr=S, wdata=op_data.
  - INT_W2: mem_we, addr=S-1, wdata={4'b0,flags_in}; update_sp, new_sp=S-2; pc_load, pc_value=op_target; done.
- RTI (RTI_R1, RTI_R2, RTI_W):
  - RTI_R1: mem_re, addr=S+1.
  - RTI_R2: flags_load, flags_out=mem_rdata[3:0]; mem_re, addr=S+2.
  - RTI_W: pc_load, pc_value=mem_rdata; update_sp, new_sp=S+2; done.
- Illegal opcode (ILL): done=1, illegal=1. No memory, register, SP, PC or flag side effects.
- After done, the engine always returns to IDLE.
- Outputs not named in a state are 0.
- op_valid and all op_* inputs are ignored outside IDLE.

## Timing
- Reset:
  - Asserting reset forces IDLE immediately, even mid-operation. Any partially completed sequence is abandoned; memory writes already performed are not undone.
  - All outputs are 0 while reset is low, including op_ready.
- op_ready is combinational: (state==IDLE) && reset. No acceptance occurs in the cycle reset deasserts unless reset went high before that edge.
- Latency from acceptance edge to done cycle: PUSH/CALL/ILL 1, POP/RET 2, INT 2, RTI 3. Done always falls in the cycle after the preceding state.
- Throughput: back-to-back operations need one IDLE cycle each. The next op therefore samples the SP already committed by the previous update_sp edge.
- Memory: reads are synchronous. mem_rdata is sampled in the cycle following mem_re.

## Configuration
- STACK_INT_EN defined: INT and RTI are implemented as above.
- STACK_INT_EN undefined:
  - INT_W*/RTI_* states are absent.
  - Opcodes 4/5 follow the illegal path (1-cycle done + illegal).
  - flags_load is tied to 0 and flags_out is tied to 0.

## Test plan
- Reset, then PUSH with sp_in=FF, op_data=5A -> next cycle mem_we, addr FF, wdata 5A, update_sp new_sp FE, done, and op_ready low that cycle.
- POP op_reg=1, sp_in=FE, mem[FF]=5A -> cycle1 mem_re addr FF; cycle2 rf_we addr 1 data 5A, new_sp FF, done; then POP op_reg=3 with mem[00]=80 at sp_in=FF -> rf_we=0, new_sp=80, stack_unf=1.
- CALL op_data=12, op_target=40, sp_in=00 -> mem[00]=12, new_sp=FF, stack_ovf=1, pc_load 40.
- INT (STACK_INT_EN) op_data=33, flags_in=9, op_target=02, sp_in=FF -> writes mem[FF]=33 then mem[FE]=09, new_sp FD, pc_load 02; then RTI at sp_in=FD -> flags_load 9 in cycle 2, pc_load 33 and new_sp FF in cycle 3.
- Opcode 6, and opcodes 4/5 with STACK_INT_EN undefined -> 1-cycle done + illegal, with no mem/rf/sp/pc strobes.
- Reset pulled low during RTI_R2 -> all outputs 0 immediately; after release, op_ready=1 and a new PUSH executes normally.
